// File: rtl/abc_vector_sequencer.sv
// Clocked stimulus sweep for the three-input sample logic: drives {a,b,c} through a vector range,
// holds each vector for HOLD_CYCLES and packs the {d,e} responses into a 16-bit result word.
module abc_vector_sequencer #(
   parameter int unsigned HOLD_CYCLES = 10,
   parameter int unsigned FIRST_VEC   = 0,
   parameter int unsigned LAST_VEC    = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        abort,
   output logic        a,
   output logic        b,
   output logic        c,
   input  logic        d_in,
   input  logic        e_in,
   output logic        busy,
   output logic        done,
   output logic [2:0]  vec_idx,
   output logic [15:0] resp,
   output logic        resp_valid
);

   typedef enum logic [1:0] {StIdle, StDrive, StDone} state_e;

   localparam logic [7:0] HoldLoad = 8'(HOLD_CYCLES - 1);
   localparam logic [2:0] FirstIdx = 3'(FIRST_VEC);
   localparam logic [2:0] LastIdx  = 3'(LAST_VEC);

   state_e     state_q;
   logic [7:0] hold_cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         hold_cnt_q <= '0;
         {a, b, c}  <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         vec_idx    <= '0;
         resp       <= '0;
         resp_valid <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (start) begin
                  resp       <= '0;
                  resp_valid <= 1'b0;
                  vec_idx    <= FirstIdx;
                  {a, b, c}  <= FirstIdx;
                  hold_cnt_q <= HoldLoad;
                  busy       <= 1'b1;
                  state_q    <= StDrive;
               end
            end
            StDrive: begin
               // abort takes priority over a capture landing on the same edge
               if (abort) begin
                  state_q    <= StIdle;
                  busy       <= 1'b0;
                  {a, b, c}  <= '0;
                  vec_idx    <= '0;
                  hold_cnt_q <= '0;
               end else if (hold_cnt_q == 8'd0) begin
                  resp[{vec_idx, 1'b0} +: 2] <= {d_in, e_in};
                  if (vec_idx == LastIdx) begin
                     state_q    <= StDone;
                     busy       <= 1'b0;
                     done       <= 1'b1;
                     resp_valid <= 1'b1;
                     {a, b, c}  <= '0;
                  end else begin
                     vec_idx    <= vec_idx + 3'd1;
                     {a, b, c}  <= vec_idx + 3'd1;
                     hold_cnt_q <= HoldLoad;
                  end
               end else begin
                  hold_cnt_q <= hold_cnt_q - 8'd1;
               end
            end
            StDone: begin
               state_q <= StIdle;
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

endmodule
